// File: rtl/multi_port_occupancy.sv
// rtl/multi_port_occupancy.sv - multi-port occupancy counter with sticky overflow/underflow flags
//
// Tracks how many of DEPTH entries are in use when up to PUSH_PORTS pushes and
// POP_PORTS pops can be requested in the same cycle. An illegal cycle is
// rejected in full: count holds and the matching sticky error flag is set.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   push           one request bit per push port
//   pop            one request bit per pop port
//   clear_err      clears both sticky error flags (a new error in the same cycle wins)
//   count          current occupancy
//   free_slots     DEPTH - count
//   empty, almost_empty, valid, almost_full, full   occupancy decodes of count
//   overflow_err, underflow_err                     sticky error flags

module multi_port_occupancy #(
   parameter int  DEPTH      = 8,
   parameter int  PUSH_PORTS = 2,
   parameter int  POP_PORTS  = 2,
   parameter int  AF_MARGIN  = 1,
   parameter int  AE_MARGIN  = 1,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PUSH_PORTS-1:0] push,
   input  logic [POP_PORTS-1:0]  pop,
   input  logic                  clear_err,
   output logic [CW-1:0]         count,
   output logic [CW-1:0]         free_slots,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  valid,
   output logic                  almost_full,
   output logic                  full,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   if (DEPTH < 2) begin : g_bad_depth
      $error("multi_port_occupancy: DEPTH must be >= 2");
   end
   if (PUSH_PORTS < 1 || PUSH_PORTS > DEPTH) begin : g_bad_push
      $error("multi_port_occupancy: PUSH_PORTS must be in 1..DEPTH");
   end
   if (POP_PORTS < 1 || POP_PORTS > DEPTH) begin : g_bad_pop
      $error("multi_port_occupancy: POP_PORTS must be in 1..DEPTH");
   end
   if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_af
      $error("multi_port_occupancy: AF_MARGIN must be in 1..DEPTH-1");
   end
   if (AE_MARGIN < 1 || AE_MARGIN > DEPTH - 1) begin : g_bad_ae
      $error("multi_port_occupancy: AE_MARGIN must be in 1..DEPTH-1");
   end

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] AE_TH   = CW'(AE_MARGIN);

   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   // All legality arithmetic runs one bit wider than count so nothing wraps
   // before the checks.
   logic [CW:0] push_cnt, pop_cnt, cnt_ext, next_ext;
   logic        ovf_now, unf_now;

   always_comb begin
      push_cnt = '0;
      for (int i = 0; i < PUSH_PORTS; i++) begin
         push_cnt = push_cnt + {{CW{1'b0}}, push[i]};
      end
   end

   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < POP_PORTS; i++) begin
         pop_cnt = pop_cnt + {{CW{1'b0}}, pop[i]};
      end
   end

   always_comb begin
      cnt_ext  = {1'b0, count_q};
      // Pops are funded only by the registered count, never by same-cycle pushes.
      unf_now  = pop_cnt > cnt_ext;
      next_ext = cnt_ext - pop_cnt + push_cnt;
      ovf_now  = !unf_now && (next_ext > DEPTH_X);
      count_d  = (unf_now || ovf_now) ? count_q : next_ext[CW-1:0];
      ovf_d    = ovf_now | (ovf_q & ~clear_err);
      unf_d    = unf_now | (unf_q & ~clear_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count         = count_q;
   assign free_slots    = DEPTH_C - count_q;
   assign empty         = (count_q == '0);
   assign valid         = ~empty;
   assign full          = (count_q == DEPTH_C);
   assign almost_full   = (count_q >= AF_TH);
   assign almost_empty  = (count_q <= AE_TH);
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

   // Flag every cycle that raises an error outside reset, and check that such
   // a cycle leaves count untouched.
   cover property (@(posedge clk) disable iff (rst) ovf_now);
   cover property (@(posedge clk) disable iff (rst) unf_now);
   assert property (@(posedge clk) disable iff (rst) (ovf_now || unf_now) |=> $stable(count_q));
   assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);

endmodule

// File: tb/tb_multi_port_occupancy.sv
// tb/tb_multi_port_occupancy.sv - self-checking bench for multi_port_occupancy

module tb_multi_port_occupancy;

   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    push = 2'b00;
   logic [1:0]    pop  = 2'b00;
   logic          clear_err = 1'b0;
   logic [CW-1:0] count, free_slots;
   logic          empty, almost_empty, valid, almost_full, full;
   logic          overflow_err, underflow_err;

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: occupancy as a plain integer plus the two sticky flags.
   int m_cnt = 0;
   bit m_ovf = 0;
   bit m_unf = 0;

   multi_port_occupancy #(
      .DEPTH(DEPTH), .PUSH_PORTS(2), .POP_PORTS(2), .AF_MARGIN(1), .AE_MARGIN(1)
   ) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .clear_err(clear_err),
      .count(count), .free_slots(free_slots), .empty(empty),
      .almost_empty(almost_empty), .valid(valid), .almost_full(almost_full),
      .full(full), .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      int p, q;
      p = $countones(push);
      q = $countones(pop);
      if (rst) begin
         m_cnt <= 0;
         m_ovf <= 0;
         m_unf <= 0;
      end else begin
         if (q > m_cnt) begin
            m_unf <= 1;
            m_ovf <= m_ovf && !clear_err;
         end else if (m_cnt - q + p > DEPTH) begin
            m_ovf <= 1;
            m_unf <= m_unf && !clear_err;
         end else begin
            m_cnt <= m_cnt - q + p;
            m_ovf <= m_ovf && !clear_err;
            m_unf <= m_unf && !clear_err;
         end
      end
   end

   always @(negedge clk) begin
      chk("model_count", 32'(count), m_cnt);
      chk("model_free", 32'(free_slots), DEPTH - m_cnt);
      chk("model_empty", 32'(empty), int'(m_cnt == 0));
      chk("model_valid", 32'(valid), int'(m_cnt != 0));
      chk("model_full", 32'(full), int'(m_cnt == DEPTH));
      chk("model_af", 32'(almost_full), int'(m_cnt >= DEPTH - 1));
      chk("model_ae", 32'(almost_empty), int'(m_cnt <= 1));
      chk("model_ovf", 32'(overflow_err), int'(m_ovf));
      chk("model_unf", 32'(underflow_err), int'(m_unf));
   end

   task automatic cyc(input logic [1:0] p, input logic [1:0] q, input logic c);
      @(negedge clk);
      #1;
      push = p;
      pop = q;
      clear_err = c;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_ae"}, 32'(almost_empty), 1);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_af"}, 32'(almost_full), 0);
      chk({tag, "_free"}, 32'(free_slots), 8);
      chk({tag, "_ovf"}, 32'(overflow_err), 0);
      chk({tag, "_unf"}, 32'(underflow_err), 0);
   endtask

   initial begin
      #1 rst = 1'b1;
      #1 chk_reset_vals("rst0");
      #10 rst = 1'b0;

      // Fill with two pushes per cycle.
      cyc(2'b11, 2'b00, 0); settle(); chk("fill1", 32'(count), 2);
      cyc(2'b11, 2'b00, 0); settle(); chk("fill2", 32'(count), 4);
      cyc(2'b11, 2'b00, 0); settle(); chk("fill3", 32'(count), 6);
      chk("fill3_af", 32'(almost_full), 0);
      cyc(2'b11, 2'b00, 0); settle(); chk("fill4", 32'(count), 8);
      chk("fill4_full", 32'(full), 1);
      chk("fill4_af", 32'(almost_full), 1);
      chk("fill4_free", 32'(free_slots), 0);

      // Balanced push/pop at full is legal; net +1 at full overflows.
      cyc(2'b01, 2'b01, 0); settle(); chk("bal_count", 32'(count), 8);
      chk("bal_ovf", 32'(overflow_err), 0);
      cyc(2'b11, 2'b01, 0); settle(); chk("ovf_count", 32'(count), 8);
      chk("ovf_flag", 32'(overflow_err), 1);
      cyc(2'b00, 2'b00, 1); settle(); chk("ovf_clr", 32'(overflow_err), 0);
      chk("idle_count", 32'(count), 8);
      cyc(2'b00, 2'b01, 0); settle(); chk("af7_count", 32'(count), 7);
      chk("af7_af", 32'(almost_full), 1);
      chk("af7_full", 32'(full), 0);

      // Drain to 1.
      cyc(2'b00, 2'b11, 0); settle(); chk("drain5", 32'(count), 5);
      cyc(2'b00, 2'b11, 0); settle(); chk("drain3", 32'(count), 3);
      cyc(2'b00, 2'b11, 0); settle(); chk("drain1", 32'(count), 1);
      chk("drain1_ae", 32'(almost_empty), 1);
      chk("drain1_valid", 32'(valid), 1);

      // Same-cycle pushes must not fund pops.
      cyc(2'b11, 2'b11, 0); settle(); chk("unf_count", 32'(count), 1);
      chk("unf_flag", 32'(underflow_err), 1);
      cyc(2'b00, 2'b11, 1); settle(); chk("unf_clr_new", 32'(underflow_err), 1);
      chk("unf_clr_new_count", 32'(count), 1);
      cyc(2'b00, 2'b00, 1); settle(); chk("unf_clr", 32'(underflow_err), 0);
      cyc(2'b00, 2'b01, 0); settle(); chk("empty_count", 32'(count), 0);
      chk("empty_flag", 32'(empty), 1);
      chk("empty_unf", 32'(underflow_err), 0);
      cyc(2'b00, 2'b01, 0); settle(); chk("unf0_flag", 32'(underflow_err), 1);
      chk("unf0_count", 32'(count), 0);

      // Build to 5 with the underflow flag still sticky, then reset mid-cycle.
      cyc(2'b11, 2'b00, 0); settle();
      cyc(2'b11, 2'b00, 0); settle();
      cyc(2'b01, 2'b00, 0); settle(); chk("pre_rst_count", 32'(count), 5);
      chk("pre_rst_unf", 32'(underflow_err), 1);
      push = 2'b11;
      #1 rst = 1'b1;
      #1 chk_reset_vals("arst");
      settle(); chk("rst_hold_count", 32'(count), 0);
      push = 2'b00;
      #1 rst = 1'b0;
      cyc(2'b01, 2'b00, 0); settle(); chk("post_rst_count", 32'(count), 1);
      cyc(2'b00, 2'b00, 0); settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_port_occupancy.md
MULTI_PORT_OCCUPANCY -- requirements
Module: multi_port_occupancy

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning tracked capacity in entries; legal range >= 2.
REQ-002 The module SHALL have parameter PUSH_PORTS, default 2, meaning push requests per cycle; legal range 1..DEPTH.
REQ-003 The module SHALL have parameter POP_PORTS, default 2, meaning pop requests per cycle; legal range 1..DEPTH.
REQ-004 The module SHALL have parameter AF_MARGIN, default 1, meaning almost-full distance from DEPTH; legal range 1..DEPTH-1.
REQ-005 The module SHALL have parameter AE_MARGIN, default 1, meaning almost-empty distance from 0; legal range 1..DEPTH-1.
REQ-006 The module SHALL have the following ports, clock and reset first:
- clk  in  1  -- sole clock, rising edge.
- rst  in  1  -- asynchronous active-high reset.
- push  in  PUSH_PORTS  -- one bit per push request; any bit pattern allowed.
- pop  in  POP_PORTS  -- one bit per pop request; any bit pattern allowed.
- clear_err  in  1  -- clears sticky error flags.
- count  out  CW=$clog2(DEPTH+1)  -- current occupancy.
- free_slots  out  CW  -- DEPTH - count.
- empty, almost_empty, valid, almost_full, full  out  1 each  -- occupancy flags.
- overflow_err, underflow_err  out  1 each  -- sticky error flags.

Function
REQ-007 The block SHALL hold count in a CW-bit register; all occupancy outputs SHALL be combinational decodes of that register only, with zero added latency and no dependence on same-cycle push/pop.
REQ-008 Each cycle: P = popcount(push), Q = popcount(pop), both zero-extended to CW+1 bits before arithmetic.
REQ-009 Pops SHALL be checked only against the registered count; same-cycle pushes SHALL NOT fund pops.
REQ-010 A cycle is legal iff Q <= count and count - Q + P <= DEPTH; on a legal cycle count SHALL update at the next edge to count + P - Q.
REQ-011 P = Q on a legal cycle, including both 0, SHALL leave count unchanged.
REQ-012 If Q > count, count SHALL hold and underflow_err SHALL set at the next edge.
REQ-013 If Q <= count and count - Q + P > DEPTH, count SHALL hold and overflow_err SHALL set at the next edge.
REQ-014 Partial acceptance of an illegal cycle SHALL NOT occur.
REQ-015 Error flags SHALL be sticky until clear_err is sampled high; when clear_err and a new error coincide in one cycle, the new error SHALL win and the flag SHALL remain 1.
REQ-016 Decodes: empty = (count == 0); valid = ~empty; full = (count == DEPTH); almost_full = (count >= DEPTH - AF_MARGIN); almost_empty = (count <= AE_MARGIN); free_slots = DEPTH - count.
REQ-017 count SHALL never exceed DEPTH and SHALL never wrap; no arithmetic path SHALL truncate to fewer than CW+1 bits before the legality checks.
REQ-018 Parameter values outside their legal ranges SHALL cause an elaboration-time error.
REQ-019 The design SHALL include simulation assertions that flag any cycle raising overflow or underflow while rst is low.

Reset
REQ-020 While rst is high, asynchronously and independent of clk: count = 0, overflow_err = 0, underflow_err = 0.
REQ-021 Reset outputs during and after rst: empty = 1, almost_empty = 1, valid = 0, full = 0, free_slots = DEPTH; almost_full = 0.
REQ-022 Reset asserted mid-operation SHALL discard the pending update and any pending error.
REQ-023 The first legal update SHALL occur at the first clk edge after rst deasserts.

Verification
REQ-024 The bench SHALL cover the following directed scenarios (DEPTH = 8, PUSH_PORTS = 2, POP_PORTS = 2, AF_MARGIN = 1, AE_MARGIN = 1 unless stated):
- Reset, then push = 2'b11 for 4 cycles -> count 2, 4, 6, 8; almost_full at count 7 and above; full at 8; free_slots 0.
- count = 8, push = 2'b01 with pop = 2'b01 -> count stays 8, no error; push = 2'b11 with pop = 2'b01 -> count 8 held, overflow_err = 1.
- count = 1, push = 2'b11 with pop = 2'b11 -> count held at 1, underflow_err = 1 (same-cycle pushes do not fund pops).
- count = 3, pop = 2'b11 -> count 1, almost_empty = 1, valid = 1; then pop = 2'b01 -> empty = 1.
- underflow_err set, then clear_err together with a new underflow -> flag remains 1; clear_err alone -> flag 0 on the next cycle.
- count = 5, rst pulsed between edges -> count = 0 and flags at reset values immediately, without waiting for a clk edge.
